// File: rtl/ct_spsram_pkg.sv
// ct_spsram_pkg
// Shared types and constants for the ct_spsram_4096x32_initiator slice.
// - state_e         : controller FSM state (StInit sweeps/waits, StRun serves requests)
// - AddrWidth       : SRAM word address width (4096 words)
// - DataWidth       : SRAM word width
// - ByteWidth       : bits per byte-enable lane
// - NumBytes        : byte lanes per word
// - DefaultRspDepth : default response FIFO depth (minimum for full read throughput)
package ct_spsram_pkg;

  localparam int unsigned AddrWidth       = 12;
  localparam int unsigned DataWidth       = 32;
  localparam int unsigned ByteWidth       = 8;
  localparam int unsigned NumBytes        = DataWidth / ByteWidth;
  localparam int unsigned DefaultRspDepth = 4;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/ct_spsram_4096x32_initiator_if.sv
// ct_spsram_4096x32_initiator_if
// Client-side request/response channel of the SRAM initiator.
// Request channel (valid/ready):
//   req_vld, req_rdy, req_wr (1 = write), req_addr, req_wdata, req_bwen (active-high bytes)
// Response channel (valid/ready, reads only, in request order):
//   rsp_vld, rsp_rdy, rsp_rdata
// Modports: master = client (cache/buffer), slave = initiator.
interface ct_spsram_4096x32_initiator_if
  import ct_spsram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth,
  parameter int unsigned DATA_WIDTH = DataWidth
);

  logic                      req_vld;
  logic                      req_rdy;
  logic                      req_wr;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_bwen;
  logic                      rsp_vld;
  logic                      rsp_rdy;
  logic [DATA_WIDTH-1:0]     rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_bwen, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_bwen, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );

endinterface

// File: rtl/ct_spsram_rsp_fifo.sv
// ct_spsram_rsp_fifo
// Depth x Width synchronous FIFO holding captured read data until the client takes it.
// Ports:
//   clk_i, rst_i    : clock, asynchronous active-high reset (FIFO empties)
//   push_i          : write push_data_i (caller guarantees space via credits)
//   push_data_i     : data to enqueue
//   pop_i           : dequeue head when valid_o is set; ignored when empty
//   valid_o, data_o : head-of-queue valid and data
// Push and pop in the same cycle are both honoured.
module ct_spsram_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: cnt_q gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ct_spsram_4096x32_initiator.sv
// ct_spsram_4096x32_initiator
// Request-side controller for the ct_f_spsram_4096x32 single-port SRAM macro.
// Accepts reads/writes on a valid/ready channel, drives the macro pins from flops, captures Q
// for reads and returns read data in order with credit-based backpressure.
// Ports:
//   CLK, RST         : clock, asynchronous active-high reset
//   bus (slave)      : request/response channel (see ct_spsram_4096x32_initiator_if)
//   init_done        : array ready, requests may be accepted
//   A, CEN, GWEN,    : SRAM address, chip enable (active-low), global write enable (active-low),
//   WEN, D           : bit write enables (active-low), write data
//   Q                : SRAM read data, valid the cycle after a read access
// Build option: define CT_SPSRAM_INIT_SWEEP_EN to write INIT_VALUE to every word after reset;
// otherwise the controller enters StRun on the first edge and contents stay undefined.
module ct_spsram_4096x32_initiator
  import ct_spsram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = AddrWidth,
  parameter int unsigned           DATA_WIDTH = DataWidth,
  parameter int unsigned           RSP_DEPTH  = DefaultRspDepth,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  ct_spsram_4096x32_initiator_if.slave bus,
  output logic                         init_done,
  output logic [ADDR_WIDTH-1:0]        A,
  output logic                         CEN,
  output logic                         GWEN,
  output logic [DATA_WIDTH-1:0]        WEN,
  output logic [DATA_WIDTH-1:0]        D,
  input  logic [DATA_WIDTH-1:0]        Q
);

  localparam int unsigned Lanes = DATA_WIDTH / ByteWidth;
  localparam int unsigned OutW  = $clog2(RSP_DEPTH + 1);

  state_e                state_q, state_d;
  logic                  init_done_q, init_done_d;
  logic                  cen_q, cen_d;
  logic                  gwen_q, gwen_d;
  logic [DATA_WIDTH-1:0] wen_q, wen_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  logic [OutW-1:0]       outstanding_q, outstanding_d;
  logic                  rd_s1_q, rd_s2_q;

  logic                  req_rdy;
  logic                  accept;
  logic                  rd_accept;
  logic                  rsp_vld;
  logic                  pop;

  logic                  sweep_last;
  logic [ADDR_WIDTH-1:0] sweep_addr;

`ifdef CT_SPSRAM_INIT_SWEEP_EN
  localparam bit SweepEn = 1'b1;

  logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;

  // Counter only runs in StInit, so it is back at zero whenever a new sweep starts.
  always_comb begin
    sweep_cnt_d = (state_q == StInit) ? sweep_cnt_q + ADDR_WIDTH'(1) : '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sweep_cnt_q <= '0;
    end else begin
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign sweep_last = &sweep_cnt_q;
  assign sweep_addr = sweep_cnt_q;
`else
  localparam bit SweepEn = 1'b0;

  assign sweep_last = 1'b1;
  assign sweep_addr = '0;
`endif

  // Handshake and credits
  assign req_rdy     = init_done_q && (outstanding_q < OutW'(RSP_DEPTH));
  assign accept      = bus.req_vld && req_rdy;
  assign rd_accept   = accept && !bus.req_wr;
  assign pop         = rsp_vld && bus.rsp_rdy;
  assign bus.req_rdy = req_rdy;
  assign bus.rsp_vld = rsp_vld;

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StInit:  if (sweep_last) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM: outputs (next values of the pin flops and init_done)
  always_comb begin
    cen_d       = 1'b1;
    gwen_d      = 1'b1;
    wen_d       = '1;
    a_d         = a_q;
    d_d         = d_q;
    // Without the sweep there is nothing to wait for, so ready follows the first edge.
    init_done_d = (state_q == StRun) || !SweepEn;
    case (state_q)
      StInit: begin
        if (SweepEn) begin
          cen_d  = 1'b0;
          gwen_d = 1'b0;
          wen_d  = '0;
          a_d    = sweep_addr;
          d_d    = INIT_VALUE;
        end
      end
      StRun: begin
        if (accept) begin
          cen_d = 1'b0;
          a_d   = bus.req_addr;
          if (bus.req_wr) begin
            gwen_d = 1'b0;
            d_d    = bus.req_wdata;
            // bwen == 0 still issues the access; all-ones WEN leaves the word intact.
            for (int unsigned k = 0; k < Lanes; k++) begin
              wen_d[k*ByteWidth +: ByteWidth] = {ByteWidth{~bus.req_bwen[k]}};
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Outstanding read credits: a read holds one from accept until its response pops.
  always_comb begin
    case ({rd_accept, pop})
      2'b10:   outstanding_d = outstanding_q + OutW'(1);
      2'b01:   outstanding_d = outstanding_q - OutW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      init_done_q   <= 1'b0;
      cen_q         <= 1'b1;
      gwen_q        <= 1'b1;
      wen_q         <= '1;
      a_q           <= '0;
      d_q           <= '0;
      outstanding_q <= '0;
      rd_s1_q       <= 1'b0;
      rd_s2_q       <= 1'b0;
    end else begin
      init_done_q   <= init_done_d;
      cen_q         <= cen_d;
      gwen_q        <= gwen_d;
      wen_q         <= wen_d;
      a_q           <= a_d;
      d_q           <= d_d;
      outstanding_q <= outstanding_d;
      // rd_s1: read on the pins this cycle; rd_s2: its Q is valid this cycle.
      rd_s1_q       <= rd_accept;
      rd_s2_q       <= rd_s1_q;
    end
  end

  ct_spsram_rsp_fifo #(
    .Depth (RSP_DEPTH),
    .Width (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (rd_s2_q),
    .push_data_i (Q),
    .pop_i       (pop),
    .valid_o     (rsp_vld),
    .data_o      (bus.rsp_rdata)
  );

  assign init_done = init_done_q;
  assign A         = a_q;
  assign CEN       = cen_q;
  assign GWEN      = gwen_q;
  assign WEN       = wen_q;
  assign D         = d_q;

endmodule

// File: tb/tb_ct_spsram_4096x32_initiator.sv
// Testbench for ct_spsram_4096x32_initiator with a behavioural SRAM macro and a read scoreboard.
// Builds with or without CT_SPSRAM_INIT_SWEEP_EN.
module tb_ct_spsram_4096x32_initiator;
  import ct_spsram_pkg::*;

  localparam logic [31:0] InitWord = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done;
  logic [11:0] a;
  logic        cen;
  logic        gwen;
  logic [31:0] wen;
  logic [31:0] d;
  logic [31:0] q;

  always #5 clk = ~clk;

  ct_spsram_4096x32_initiator_if bus ();

  ct_spsram_4096x32_initiator #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .RSP_DEPTH  (4),
    .INIT_VALUE (InitWord)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .init_done (init_done),
    .A         (a),
    .CEN       (cen),
    .GWEN      (gwen),
    .WEN       (wen),
    .D         (d),
    .Q         (q)
  );

  // Behavioural single-port SRAM: bit-masked write, registered read.
  logic [31:0] sram [4096];
  always @(posedge clk) begin
    if (!cen) begin
      if (!gwen) sram[a] <= (sram[a] & wen) | (d & ~wen);
      else       q <= sram[a];
    end
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_mem [4096];
  logic [31:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: pops happen on the next posedge, so each response is seen once here.
  always @(negedge clk) begin
    if (!rst && bus.rsp_vld && bus.rsp_rdy) begin
      if (exp_q.size() == 0) check_eq("rsp_unexpected", 32'd1, 32'd0);
      else                   check_eq("rsp_data", bus.rsp_rdata, exp_q.pop_front());
    end
  end

  // Drive one request; returns #1 after the accepting edge. Scoreboard updated at accept.
  task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [3:0] bwen);
    int waited = 0;
    @(negedge clk);
    bus.req_vld   = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_bwen  = bwen;
    while (!bus.req_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_rdy) begin
      check_eq("req_accept_timeout", 32'd0, 32'd1);
      bus.req_vld = 1'b0;
      return;
    end
    if (wr) begin
      for (int k = 0; k < 4; k++) begin
        if (bwen[k]) ref_mem[addr][k*8 +: 8] = wdata[k*8 +: 8];
      end
    end else begin
      exp_q.push_back(ref_mem[addr]);
    end
    @(posedge clk);
    #1 bus.req_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1 check_eq(tag, exp_q.size(), 32'd0);
  endtask

  // Called #1 after a posedge with rst high.
  task automatic release_reset();
`ifdef CT_SPSRAM_INIT_SWEEP_EN
    int bad = 0;
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      @(posedge clk);
      #1;
      if (cen !== 1'b0 || gwen !== 1'b0 || wen !== 32'h0 || d !== InitWord ||
          a !== 12'(i) || bus.req_rdy !== 1'b0 || init_done !== 1'b0) bad++;
    end
    check_eq("sweep_pins", bad, 32'd0);
    @(posedge clk);
    #1;
    check_eq("init_done_rise", init_done, 1'b1);
    check_eq("sweep_end_cen", cen, 1'b1);
`else
    rst = 1'b0;
    check_eq("init_done_pre", init_done, 1'b0);
    @(posedge clk);
    #1;
    check_eq("init_done_rise", init_done, 1'b1);
    check_eq("idle_cen", cen, 1'b1);
`endif
  endtask

  initial begin
    int stale;
    bus.req_vld   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_bwen  = '0;
    bus.rsp_rdy   = 1'b1;
    for (int i = 0; i < 4096; i++) ref_mem[i] = InitWord;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cen", cen, 1'b1);
    check_eq("rst_gwen", gwen, 1'b1);
    check_eq("rst_wen", wen, 32'hFFFF_FFFF);
    check_eq("rst_a", a, 32'h0);
    check_eq("rst_d", d, 32'h0);
    check_eq("rst_rsp_vld", bus.rsp_vld, 1'b0);
    check_eq("rst_req_rdy", bus.req_rdy, 1'b0);
    check_eq("rst_init_done", init_done, 1'b0);
    release_reset();

    // Full write then read, with response latency
    send(1'b1, 12'h123, 32'hDEAD_BEEF, 4'hF);
    send(1'b0, 12'h123, 32'h0, 4'h0);
    check_eq("lat_e0_rsp_vld", bus.rsp_vld, 1'b0);
    @(posedge clk);
    #1 check_eq("lat_e1_rsp_vld", bus.rsp_vld, 1'b0);
    @(posedge clk);
    #1 check_eq("lat_e2_rsp_vld", bus.rsp_vld, 1'b1);
    wait_drain("drain_full_write");

    // Partial byte write, then a bwen=0 write that must change nothing
    send(1'b1, 12'h123, 32'h1122_3344, 4'b0101);
    send(1'b0, 12'h123, 32'h0, 4'h0);
    send(1'b1, 12'h123, 32'hFFFF_FFFF, 4'b0000);
    send(1'b0, 12'h123, 32'h0, 4'h0);
    wait_drain("drain_bwen");

    // Top address, read on the cycle after the write; pins then hold while idle
    send(1'b1, 12'hFFF, 32'hA5A5_A5A5, 4'hF);
    send(1'b0, 12'hFFF, 32'h0, 4'h0);
    wait_drain("drain_top_addr");
    check_eq("idle_hold_a", a, 32'h0000_0FFF);
    check_eq("idle_hold_d", d, 32'hA5A5_A5A5);
    check_eq("idle_cen_hi", cen, 1'b1);

    // Credit backpressure: 6 reads with rsp_rdy low, only 4 fit
    for (int i = 0; i < 6; i++) send(1'b1, 12'h200 + 12'(i), 32'hC0DE_0000 + 32'(i), 4'hF);
    bus.rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 12'h200 + 12'(i), 32'h0, 4'h0);
    check_eq("credit_full_rdy", bus.req_rdy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("credit_stall_rdy", bus.req_rdy, 1'b0);
    check_eq("credit_rsp_vld", bus.rsp_vld, 1'b1);
    fork
      begin
        send(1'b0, 12'h204, 32'h0, 4'h0);
        send(1'b0, 12'h205, 32'h0, 4'h0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.rsp_rdy = 1'b1;
      end
    join
    wait_drain("drain_credit");

    // Reset in the middle of a read burst
    @(posedge clk);
    #1 bus.rsp_rdy = 1'b0;
    send(1'b0, 12'h123, 32'h0, 4'h0);
    send(1'b0, 12'hFFF, 32'h0, 4'h0);
    send(1'b0, 12'h201, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1 check_eq("pre_rst_rsp_vld", bus.rsp_vld, 1'b1);
    send(1'b0, 12'h202, 32'h0, 4'h0);
    rst = 1'b1;
    #1;
    check_eq("midrst_rsp_vld", bus.rsp_vld, 1'b0);
    check_eq("midrst_cen", cen, 1'b1);
    check_eq("midrst_req_rdy", bus.req_rdy, 1'b0);
    exp_q.delete();
`ifdef CT_SPSRAM_INIT_SWEEP_EN
    for (int i = 0; i < 4096; i++) ref_mem[i] = InitWord;
`endif
    bus.rsp_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    release_reset();
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_vld) stale++;
    end
    check_eq("no_stale_rsp", stale, 32'd0);

    // Still functional after reset
    send(1'b0, 12'h123, 32'h0, 4'h0);
    wait_drain("drain_post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
